uart_rx: RTL

UART receiver for the inter-board link, the receive end of the serial line the game board uses to exchange state with the second board. It recovers 8N1-style frames from an asynchronous `rx` pin, presents each byte with a one-cycle valid strobe, and flags framing errors. It is a Moore-style FSM plus a bit-timing counter and a shift register, clocked from the system pixel clock.

---
 rtl/uart_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/stop frames from an asynchronous rx line,
// strobes each good byte on dout_valid and a low stop bit on frame_err.
module uart_rx #(
    parameter int unsigned CLK_HZ    = 65_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 frame_err
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;

    logic w_half;
    logic w_full;
    logic w_last_bit;
    logic w_cnt_clr;
    logic w_bit_clr;
    logic w_shift_en;
    logic w_good;
    logic w_ferr;

    assign w_half     = (r_cnt == CNT_W'(HALF - 1));
    assign w_full     = (r_cnt == CNT_W'(DIV - 1));
    assign w_last_bit = (r_bit == BIT_W'(DATA_BITS - 1));

    // Two-flop synchronizer; idle-high reset avoids a false start after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_rx_s) w_next = S_START;
            S_START: if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_full && w_last_bit) w_next = S_STOP;
            S_STOP:  if (w_full) w_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_clr  = 1'b1;
        w_bit_clr  = 1'b1;
        w_shift_en = 1'b0;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_START: w_cnt_clr = w_half;
            S_DATA: begin
                w_cnt_clr  = w_full;
                w_bit_clr  = 1'b0;
                w_shift_en = w_full;
            end
            S_STOP: begin
                w_cnt_clr = w_full;
                w_good    = w_full && r_rx_s;
                w_ferr    = w_full && !r_rx_s;
            end
            default: ;
        endcase
    end

    // Bit timing, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (w_bit_clr)       r_bit <= '0;
            else if (w_shift_en) r_bit <= r_bit + BIT_W'(1);
            if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= w_good;
            frame_err  <= w_ferr;
            if (w_good) dout <= r_shift;
        end
    end

endmodule
